// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, Status/Cause bit positions.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_IM_HI  = 15;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  // Only IE, EXL and IM exist in Status; everything else reads as zero.
  localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;

  function automatic logic [31:0] cause_pack(input logic       bd,
                                             input logic       ti,
                                             input logic [7:0] ip,
                                             input logic [4:0] code);
    logic [31:0] w;
    w = '0;
    w[CA_BD]                   = bd;
    w[CA_TI]                   = ti;
    w[CA_IP_LO +: 8]           = ip;
    w[CA_EXC_LO +: 5]          = code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with the timer-interrupt flag. Only built with CP0_TIMER_EN.
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  // Count free-runs (a load replaces the increment); TI latches on a match, a Compare write clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + 32'd1;
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// MIPS32 CP0 with exception/interrupt prioritisation and redirect generation.
// Optional timer (Count/Compare/TI) is built when the macro CP0_TIMER_EN is defined.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HW_INT = 5,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mfc0,
  input  logic                  mtc0,
  input  logic                  eret,
  input  logic [4:0]            rd,
  input  logic [31:0]           reg_in,
  output logic [31:0]           reg_out,
  input  logic [31:0]           pc_in,
  input  logic                  is_bd,
  input  logic [31:0]           bad_addr,
  input  logic                  exc_adel,
  input  logic                  exc_ades,
  input  logic                  exc_ri,
  input  logic                  exc_sys,
  input  logic                  exc_bp,
  input  logic                  exc_ov,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic                  exc_taken,
  output logic [31:0]           exc_target,
  output logic [31:0]           epc
);

  logic [31:0] status_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic        bd_q;
  logic [4:0]  exc_code_q;
  logic [1:0]  ip_sw_q;
  logic [5:0]  ip_hw_q;
  logic [5:0]  hw_ext;
  logic [7:0]  ip;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic        int_pending;
  logic        exc_any;
  logic [4:0]  exc_code;

`ifdef CP0_TIMER_EN
  logic count_we;
  logic compare_we;

  // A discarded mtc0 (exception in the same cycle) must not touch the timer either.
  assign count_we   = mtc0 & ~exc_any & (rd == REG_COUNT);
  assign compare_we = mtc0 & ~exc_any & (rd == REG_COMPARE);

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (reg_in),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  // Zero-extend the hardware lines onto the six IP[7:2] slots.
  always_comb begin
    hw_ext                   = '0;
    hw_ext[NUM_HW_INT-1:0]   = hw_int;
  end

  // IP7 is shared between the timer flag and the top hardware line.
  assign ip = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};

  // Pick the highest-priority exception; interrupts only when enabled and not already in EXL.
  always_comb begin
    int_pending = status_q[ST_IE] & ~status_q[ST_EXL] &
                  (|(ip & status_q[ST_IM_HI:ST_IM_LO]));
    exc_any  = 1'b1;
    exc_code = EXC_INT;
    if (exc_adel)         exc_code = EXC_ADEL;
    else if (exc_ri)      exc_code = EXC_RI;
    else if (exc_sys)     exc_code = EXC_SYS;
    else if (exc_bp)      exc_code = EXC_BP;
    else if (exc_ov)      exc_code = EXC_OV;
    else if (exc_ades)    exc_code = EXC_ADES;
    else if (int_pending) exc_code = EXC_INT;
    else                  exc_any  = 1'b0;
  end

  // Redirect: exception vector wins over eret; everything held low during reset.
  always_comb begin
    exc_taken  = 1'b0;
    exc_target = '0;
    if (!rst) begin
      if (exc_any) begin
        exc_taken  = 1'b1;
        exc_target = EXC_VECTOR;
      end else if (eret) begin
        exc_taken  = 1'b1;
        exc_target = epc_q;
      end
    end
  end

  // mfc0 read mux; unimplemented registers and idle cycles read zero.
  always_comb begin
    reg_out = '0;
    if (mfc0 && !rst) begin
      case (rd)
        REG_BADVADDR: reg_out = badvaddr_q;
        REG_COUNT:    reg_out = count;
        REG_COMPARE:  reg_out = compare;
        REG_STATUS:   reg_out = status_q;
        REG_CAUSE:    reg_out = cause_pack(bd_q, ti, ip, exc_code_q);
        REG_EPC:      reg_out = epc_q;
        default:      reg_out = '0;
      endcase
    end
  end

  assign epc = epc_q;

  // Architectural state update: exception entry, otherwise mtc0 writes and eret.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RST & STATUS_MASK;
      epc_q      <= '0;
      badvaddr_q <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
    end else begin
      ip_hw_q <= hw_ext;
      if (exc_any) begin
        exc_code_q       <= exc_code;
        status_q[ST_EXL] <= 1'b1;
        // A nested exception keeps the original return point.
        if (!status_q[ST_EXL]) begin
          epc_q <= is_bd ? pc_in - 32'd4 : pc_in;
          bd_q  <= is_bd;
        end
        if (exc_code == EXC_ADEL || exc_code == EXC_ADES) begin
          badvaddr_q <= bad_addr;
        end
      end else begin
        if (mtc0) begin
          case (rd)
            REG_STATUS: status_q <= reg_in & STATUS_MASK;
            REG_CAUSE:  ip_sw_q  <= reg_in[CA_IP_LO +: 2];
            REG_EPC:    epc_q    <= reg_in;
            default:    ;
          endcase
        end
        if (eret) begin
          status_q[ST_EXL] <= 1'b0;
        end
      end
    end
  end

endmodule
